ycbcr2rgb: RTL

Multi-lane YCbCr-to-RGB colour converter and the inverse of the RGB2YCbCr front end. It is used on the output side of the preprocessing path to rebuild RGB888 pixels for display and debug readback. LANES pixels are converted in parallel through a 3-stage pipeline. Full valid/ready backpressure lets it sit in front of a stalling sink.

---
 rtl/ycbcr2rgb.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ycbcr2rgb.sv
//============================================================================
// Module      : ycbcr2rgb
// Description : Multi-lane YCbCr to RGB888 converter, 3-stage pipeline with
//               valid/ready backpressure. Optional macro
//               YCC2RGB_STUDIO_RANGE_EN selects BT.601 studio-range equations
//               (default: full-range JPEG equations).
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module ycbcr2rgb #(
    parameter int LANES       = 8,
    parameter int PIPE_STAGES = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [8*LANES-1:0]    i_y_data,
    input  logic [8*LANES-1:0]    i_cb_data,
    input  logic [8*LANES-1:0]    i_cr_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [24*LANES-1:0]   o_rgb_data
);

    // The pipeline depth is fixed; the parameter is informational only.
    if (PIPE_STAGES != 3) begin : g_stage_check
        $error("ycbcr2rgb: PIPE_STAGES must be 3");
    end

    // Coefficients. The luma term is always pre-scaled in stage 2 so that
    // R and B reduce to a single rounded sum in stage 3 for both builds.
`ifdef YCC2RGB_STUDIO_RANGE_EN
    localparam logic signed [17:0] c_k_y  = 18'sd298;
    localparam logic signed [17:0] c_k_r  = 18'sd409;
    localparam logic signed [17:0] c_k_gb = 18'sd100;
    localparam logic signed [17:0] c_k_gr = 18'sd208;
    localparam logic signed [17:0] c_k_b  = 18'sd516;
    localparam logic signed [9:0]  c_y_off = 10'sd16;
`else
    localparam logic signed [17:0] c_k_y  = 18'sd256;
    localparam logic signed [17:0] c_k_r  = 18'sd359;
    localparam logic signed [17:0] c_k_gb = 18'sd88;
    localparam logic signed [17:0] c_k_gr = 18'sd183;
    localparam logic signed [17:0] c_k_b  = 18'sd454;
    localparam logic signed [9:0]  c_y_off = 10'sd0;
`endif
    localparam logic signed [19:0] c_round = 20'sd128;

    function automatic logic signed [19:0] sx20(input logic signed [17:0] v);
        return {{2{v[17]}}, v};
    endfunction

    function automatic logic [7:0] clamp8(input logic signed [11:0] v);
        if (v[11])
            return 8'd0;
        else if (v[10:8] != 3'd0)
            return 8'd255;
        else
            return v[7:0];
    endfunction

    logic r_v1, r_v2, r_v3;
    logic w_en1, w_en2, w_en3;

    // A stage may load when it is empty or the stage after it is moving.
    assign w_en3   = !r_v3 || i_ready;
    assign w_en2   = !r_v2 || w_en3;
    assign w_en1   = !r_v1 || w_en2;
    assign o_ready = w_en1;
    assign o_valid = r_v3;

    // Shared stage-valid chain; all lanes advance together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            if (w_en1) r_v1 <= i_valid;
            if (w_en2) r_v2 <= r_v1;
            if (w_en3) r_v3 <= r_v2;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic        [7:0]  w_y, w_cb, w_cr;
        logic signed [9:0]  r_s1_y;
        logic signed [8:0]  r_s1_cb, r_s1_cr;
        logic signed [17:0] w_y_x, w_cb_x, w_cr_x;
        logic signed [17:0] r_s2_y, r_s2_r, r_s2_gb, r_s2_gr, r_s2_b;
        logic signed [11:0] w_r, w_g, w_b;
        logic        [23:0] r_s3_rgb;

        assign w_y  = i_y_data[8*k +: 8];
        assign w_cb = i_cb_data[8*k +: 8];
        assign w_cr = i_cr_data[8*k +: 8];

        assign w_y_x  = {{8{r_s1_y[9]}}, r_s1_y};
        assign w_cb_x = {{9{r_s1_cb[8]}}, r_s1_cb};
        assign w_cr_x = {{9{r_s1_cr[8]}}, r_s1_cr};

        // Stage 3 combinational: rounded floor shift, then channel clamp.
        assign w_r = 12'((sx20(r_s2_y) + sx20(r_s2_r) + c_round) >>> 8);
        assign w_b = 12'((sx20(r_s2_y) + sx20(r_s2_b) + c_round) >>> 8);
`ifdef YCC2RGB_STUDIO_RANGE_EN
        assign w_g = 12'((sx20(r_s2_y) - sx20(r_s2_gb) - sx20(r_s2_gr) + c_round) >>> 8);
`else
        // Full range rounds only the chroma offset, then subtracts it from Y.
        logic signed [11:0] w_g_off;
        assign w_g_off = 12'((sx20(r_s2_gb) + sx20(r_s2_gr) + c_round) >>> 8);
        assign w_g     = $signed({2'b00, r_s2_y[17:8]}) - w_g_off;
`endif

        // Stage 1: register luma and remove the chroma (and luma) offsets.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_s1_y  <= '0;
                r_s1_cb <= '0;
                r_s1_cr <= '0;
            end else if (w_en1) begin
                r_s1_y  <= $signed({2'b00, w_y}) - c_y_off;
                r_s1_cb <= $signed({1'b0, w_cb}) - 9'sd128;
                r_s1_cr <= $signed({1'b0, w_cr}) - 9'sd128;
            end
        end

        // Stage 2: register the signed coefficient products.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_s2_y  <= '0;
                r_s2_r  <= '0;
                r_s2_gb <= '0;
                r_s2_gr <= '0;
                r_s2_b  <= '0;
            end else if (w_en2) begin
                r_s2_y  <= c_k_y  * w_y_x;
                r_s2_r  <= c_k_r  * w_cr_x;
                r_s2_gb <= c_k_gb * w_cb_x;
                r_s2_gr <= c_k_gr * w_cr_x;
                r_s2_b  <= c_k_b  * w_cb_x;
            end
        end

        // Stage 3: register the clamped RGB888 pixel to the output.
        always_ff @(posedge i_clk) begin
            if (i_rst)
                r_s3_rgb <= '0;
            else if (w_en3)
                r_s3_rgb <= {clamp8(w_r), clamp8(w_g), clamp8(w_b)};
        end

        assign o_rgb_data[24*k +: 24] = r_s3_rgb;
    end

endmodule

`default_nettype wire
